// File: rtl/conv1x1_stream_feeder.sv
// Feeds the serial 1x1 conv core from a weight memory and an activation memory.
// Optional build macro: CONV_FEED_WAIT_RESULT_EN (pace pixels on core_out_valid).
module conv1x1_stream_feeder #(
  parameter int DATA_WIDTH   = 16,
  parameter int IN_CHANNELS  = 16,
  parameter int OUT_CHANNELS = 4,
  parameter int NUM_PIXELS   = 1,
  parameter int DRAIN_CYCLES = OUT_CHANNELS*(IN_CHANNELS+3)+2,
  localparam int KBEATS = IN_CHANNELS*OUT_CHANNELS,
  localparam int WAW = (KBEATS > 1) ? $clog2(KBEATS) : 1,
  localparam int XAW = (NUM_PIXELS*IN_CHANNELS > 1) ? $clog2(NUM_PIXELS*IN_CHANNELS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  w_rd_en,
  output logic [WAW-1:0]        w_addr,
  input  logic [DATA_WIDTH-1:0] w_rd_data,
  output logic                  x_rd_en,
  output logic [XAW-1:0]        x_addr,
  input  logic [DATA_WIDTH-1:0] x_rd_data,
  output logic                  load_kernel,
  output logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_valid,
  input  logic                  core_out_valid
);

  typedef enum logic [2:0] {IDLE, K_PRE, K_LOAD, X_PRE, X_SEND, DRAIN, FINISH} state_e;

  localparam int CNT_MAX = (KBEATS > DRAIN_CYCLES) ?
                           ((KBEATS > IN_CHANNELS) ? KBEATS : IN_CHANNELS) :
                           ((DRAIN_CYCLES > IN_CHANNELS) ? DRAIN_CYCLES : IN_CHANNELS);
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam int PW = $clog2(NUM_PIXELS + 1);

  state_e          state_q;
  logic            kernel_sent_q;
  logic            busy_q;
  logic            done_q;
  logic            w_rd_en_q;
  logic            x_rd_en_q;
  logic            load_kernel_q;
  logic            in_valid_q;
  logic [WAW-1:0]  w_addr_q;
  logic [XAW-1:0]  x_addr_q;
  logic [CW-1:0]   cnt_q;
  logic [PW-1:0]   pixel_q;
  logic            drain_exit;

  function automatic logic [XAW-1:0] x_addr_of(input int pixel, input int ic);
    return XAW'(pixel*IN_CHANNELS + ic);
  endfunction

`ifdef CONV_FEED_WAIT_RESULT_EN
  logic seen_q;
  // Leave DRAIN on the first low sample after the core's result window was seen.
  assign drain_exit = seen_q && !core_out_valid;
`else
  logic unused_core_out_valid;
  assign unused_core_out_valid = core_out_valid;
  assign drain_exit = (cnt_q == CW'(DRAIN_CYCLES-1));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      kernel_sent_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      w_rd_en_q     <= 1'b0;
      x_rd_en_q     <= 1'b0;
      load_kernel_q <= 1'b0;
      in_valid_q    <= 1'b0;
      w_addr_q      <= '0;
      x_addr_q      <= '0;
      cnt_q         <= '0;
      pixel_q       <= '0;
`ifdef CONV_FEED_WAIT_RESULT_EN
      seen_q        <= 1'b0;
`endif
    end else begin
      done_q        <= 1'b0;
      w_rd_en_q     <= 1'b0;
      x_rd_en_q     <= 1'b0;
      load_kernel_q <= 1'b0;
      in_valid_q    <= 1'b0;
      w_addr_q      <= '0;
      x_addr_q      <= '0;
      // Outputs are registered: each branch sets the strobes for the state it enters.
      case (state_q)
        IDLE: begin
          if (start) begin
            busy_q  <= 1'b1;
            pixel_q <= '0;
            cnt_q   <= '0;
            if (!kernel_sent_q) begin
              state_q       <= K_PRE;
              load_kernel_q <= 1'b1;
              w_rd_en_q     <= 1'b1;
            end else begin
              state_q    <= X_PRE;
              in_valid_q <= 1'b1;
              x_rd_en_q  <= 1'b1;
            end
          end
        end
        K_PRE: begin
          state_q       <= K_LOAD;
          cnt_q         <= '0;
          load_kernel_q <= 1'b1;
          if (KBEATS > 1) begin
            w_rd_en_q <= 1'b1;
            w_addr_q  <= WAW'(1);
          end
        end
        K_LOAD: begin
          if (cnt_q == CW'(KBEATS-1)) begin
            state_q       <= X_PRE;
            kernel_sent_q <= 1'b1;
            in_valid_q    <= 1'b1;
            x_rd_en_q     <= 1'b1;
            x_addr_q      <= x_addr_of(int'(pixel_q), 0);
          end else begin
            cnt_q         <= cnt_q + CW'(1);
            load_kernel_q <= 1'b1;
            if (int'(cnt_q) + 2 < KBEATS) begin
              w_rd_en_q <= 1'b1;
              w_addr_q  <= WAW'(int'(cnt_q) + 2);
            end
          end
        end
        X_PRE: begin
          state_q    <= X_SEND;
          cnt_q      <= '0;
          in_valid_q <= 1'b1;
          if (IN_CHANNELS > 1) begin
            x_rd_en_q <= 1'b1;
            x_addr_q  <= x_addr_of(int'(pixel_q), 1);
          end
        end
        X_SEND: begin
          if (cnt_q == CW'(IN_CHANNELS-1)) begin
            state_q <= DRAIN;
            cnt_q   <= '0;
`ifdef CONV_FEED_WAIT_RESULT_EN
            seen_q  <= 1'b0;
`endif
          end else begin
            cnt_q      <= cnt_q + CW'(1);
            in_valid_q <= 1'b1;
            if (int'(cnt_q) + 2 < IN_CHANNELS) begin
              x_rd_en_q <= 1'b1;
              x_addr_q  <= x_addr_of(int'(pixel_q), int'(cnt_q) + 2);
            end
          end
        end
        DRAIN: begin
`ifdef CONV_FEED_WAIT_RESULT_EN
          if (core_out_valid) seen_q <= 1'b1;
`else
          cnt_q <= cnt_q + CW'(1);
`endif
          if (drain_exit) begin
            if (int'(pixel_q) + 1 < NUM_PIXELS) begin
              state_q    <= X_PRE;
              pixel_q    <= pixel_q + PW'(1);
              in_valid_q <= 1'b1;
              x_rd_en_q  <= 1'b1;
              x_addr_q   <= x_addr_of(int'(pixel_q) + 1, 0);
            end else begin
              state_q <= FINISH;
              done_q  <= 1'b1;
            end
          end
        end
        FINISH: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Data bus follows the state so it drops to zero with reset, without a register stage.
  always_comb begin
    in_data = '0;
    case (state_q)
      K_PRE, K_LOAD: in_data = w_rd_data;
      X_PRE, X_SEND: in_data = x_rd_data;
      default:       in_data = '0;
    endcase
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign w_rd_en     = w_rd_en_q;
  assign w_addr      = w_addr_q;
  assign x_rd_en     = x_rd_en_q;
  assign x_addr      = x_addr_q;
  assign load_kernel = load_kernel_q;
  assign in_valid    = in_valid_q;

endmodule
